mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Sequential successor of the combinational memory interface: two requesters (instruction fetch, data
//  load/store) share one Avalon-style bus. Arbitrates, registers bus signals, holds them across waitrequest,
//  does all MIPS load/store lane steering (LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW), and returns one-cycle responses.
//  Sits between the CPU control/ALU and the external memory bus.
// PARAMETERS
//  TIMEOUT    0    wait cycles before a stalled transfer aborts with err; 0 = never time out
//  DATA_FIRST 1    1: data request wins a simultaneous arbitration; 0: fetch wins
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  f_req          in   1   fetch request, sampled only when ready=1
//  f_addr         in   32  fetch address; always full-word LW semantics, must be word-aligned
//  d_req          in   1   data request, sampled only when ready=1
//  d_op           in   4   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW; others illegal
//  d_addr         in   32  effective address (ALU result)
//  d_wdata        in   32  store data / rt merge source for LWL,LWR
//  ready          out  1   high only in IDLE; request accepted on clk edge with ready & (f_req|d_req)
//  f_valid        out  1   one-cycle pulse: fetch response on rdata
//  d_valid        out  1   one-cycle pulse: data response on rdata (also for stores)
//  rdata          out  32  response data, stable while *_valid high
//  err            out  1   qualifies *_valid: misaligned, illegal op or timeout; rdata=0 when set
//  mem_halt       out  1   ~ready; CPU stalls while high
//  address        out  32  bus word address {addr[31:2],2'b00}
//  read / write   out  1   bus strobes, registered
//  byteenable     out  4   bus byte lanes, lane n = byte n, little-endian
//  writedata      out  32  bus write data
//  waitrequest    in   1   bus stall
//  readdata       in   32  bus read data, valid in the cycle read=1 & waitrequest=0
// BEHAVIOUR
//  Reset: state IDLE; ready=1; read, write, f_valid, d_valid and err=0; address, byteenable, writedata and rdata=0.
//  Reset mid-transfer drops strobes immediately and sends no response.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//   IDLE: on accept, latch requester/op/addr/wdata and go to BUS with strobes registered; wait counter cleared.
//    Illegal op, LH/LHU/SH with addr[0]=1, or LW/SW/fetch with addr[1:0]!=0: go to RESP with err=1,
//    no bus cycle.
//   BUS: hold address, byteenable, writedata and strobe constant while waitrequest=1. On waitrequest=0,
//    capture readdata (loads), drop strobes next edge, go to RESP. With TIMEOUT>0, when counter==TIMEOUT
//    and still waiting: drop strobes, RESP with err=1.
//   RESP: assert f_valid or d_valid for exactly one cycle, then IDLE.
//  Minimum latency accept->valid: 2 cycles with waitrequest=0.
//  Arbitration: only one request is taken per IDLE visit. The loser must hold its request.
//  byteenable: word/LWL/LWR=1111. Byte=1<<a (a=addr[1:0]). Half=0011 (a=0) or 1100 (a=2).
//  writedata: SB={4{wdata[7:0]}}, SH={2{wdata[15:0]}}, SW=wdata.
//  Load steering, m=readdata, r=d_wdata:
//   LB/LBU: byte a, sign/zero-extended. LH/LHU: half a[1], sign/zero-extended. LW: m.
//   LWL: a0 {m[7:0],r[23:0]}, a1 {m[15:0],r[15:0]}, a2 {m[23:0],r[7:0]}, a3 m.
//   LWR: a0 m, a1 {r[31:24],m[31:8]}, a2 {r[31:16],m[31:16]}, a3 {r[31:8],m[31:24]}.
//  Stores: rdata=0 in the response.
//  read and write are never high together. Strobes are never high outside BUS.
// TESTING
//  LW 0x100, waitrequest low, readdata=0xDEADBEEF: read one cycle, byteenable=1111; d_valid 2 cycles after
//   accept with rdata=0xDEADBEEF.
//  LB 0x103, readdata=0x80000000, waitrequest high 3 cycles: signals held 4 cycles, byteenable=1000;
//   rdata=0xFFFFFF80. LBU gives 0x00000080.
//  SH 0x102, wdata=0x1234ABCD: write=1, byteenable=1100, writedata=0xABCDABCD; d_valid with err=0.
//  LWL 0x101, r=0x11223344, m=0xAABBCCDD: rdata=0xCCDD3344. LWR same inputs: rdata=0x11AABBCC.
//  f_req and d_req together with DATA_FIRST=1: data served first, fetch accepted next IDLE.
//   LH 0x101: err=1 and no bus strobe.
//  TIMEOUT=4, waitrequest stuck high: strobe drops after 4 wait cycles, d_valid&err.
//   reset_n low mid-BUS: strobes 0 at once.

Source files
------------

// File: rtl/mem_access_unit.sv
// Shared fetch/data memory access unit: arbitrates two requesters onto one
// Avalon-style bus, steers MIPS load/store byte lanes and returns a one-cycle
// response pulse per transfer.
module mem_access_unit #(
    parameter int unsigned TIMEOUT    = 0,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        d_req,
    input  logic [3:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        ready,
    output logic        f_valid,
    output logic        d_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_halt,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              is_data_q, is_data_nxt;
    logic [3:0]        op_q, op_nxt;
    logic [1:0]        alo_q, alo_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [31:0]       address_nxt, writedata_nxt, rdata_nxt;
    logic [3:0]        be_nxt;
    logic              read_nxt, write_nxt, f_valid_nxt, d_valid_nxt, err_nxt;
    logic              ready_nxt;

    logic              take_d;
    logic [3:0]        sel_op;
    logic [31:0]       sel_addr;
    logic              sel_ok;

    // Legal opcode with an address aligned to its access size
    function automatic logic op_ok(input logic [3:0] op, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: ok = 1'b1;
            OP_LH, OP_LHU, OP_SH:                 ok = ~a[0];
            OP_LW, OP_SW:                         ok = (a == 2'b00);
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by the access
    function automatic logic [3:0] lane_mask(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
            default:              be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so byteenable picks the right one
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] w);
        logic [31:0] d;
        d = w;
        case (op)
            OP_SB:   d = {4{w[7:0]}};
            OP_SH:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Load result from the bus word m, merging with rt (r) for LWL/LWR
    function automatic logic [31:0] load_steer(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] m, input logic [31:0] r);
        logic [31:0] ld;
        logic [7:0]  b;
        logic [15:0] h;
        b  = 8'(m >> {a, 3'b000});
        h  = a[1] ? m[31:16] : m[15:0];
        ld = m;
        case (op)
            OP_LB:  ld = {{24{b[7]}}, b};
            OP_LBU: ld = {24'd0, b};
            OP_LH:  ld = {{16{h[15]}}, h};
            OP_LHU: ld = {16'd0, h};
            OP_LWL: begin
                case (a)
                    2'd0:    ld = {m[7:0],  r[23:0]};
                    2'd1:    ld = {m[15:0], r[15:0]};
                    2'd2:    ld = {m[23:0], r[7:0]};
                    default: ld = m;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    ld = m;
                    2'd1:    ld = {r[31:24], m[31:8]};
                    2'd2:    ld = {r[31:16], m[31:16]};
                    default: ld = {r[31:8],  m[31:24]};
                endcase
            end
            default: ld = m;
        endcase
        return ld;
    endfunction

    // Arbitration winner and its decoded access; fetch is always an aligned LW
    assign take_d   = d_req & (DATA_FIRST | ~f_req);
    assign sel_op   = take_d ? d_op : OP_LW;
    assign sel_addr = take_d ? d_addr : f_addr;
    assign sel_ok   = op_ok(sel_op, sel_addr[1:0]);

    // Next-state, latched request and registered-output values
    always_comb begin
        state_nxt     = state;
        is_data_nxt   = is_data_q;
        op_nxt        = op_q;
        alo_nxt       = alo_q;
        wdata_nxt     = wdata_q;
        cnt_nxt       = cnt_q;
        address_nxt   = address;
        be_nxt        = byteenable;
        writedata_nxt = writedata;
        read_nxt      = read;
        write_nxt     = write;
        rdata_nxt     = rdata;
        f_valid_nxt   = 1'b0;
        d_valid_nxt   = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (f_req | d_req) begin
                    is_data_nxt = take_d;
                    op_nxt      = sel_op;
                    alo_nxt     = sel_addr[1:0];
                    wdata_nxt   = d_wdata;
                    cnt_nxt     = '0;
                    if (!sel_ok) begin
                        state_nxt   = S_RESP;
                        d_valid_nxt = take_d;
                        f_valid_nxt = ~take_d;
                        err_nxt     = 1'b1;
                        rdata_nxt   = '0;
                    end else begin
                        state_nxt   = S_BUS;
                        address_nxt = {sel_addr[31:2], 2'b00};
                        be_nxt      = lane_mask(sel_op, sel_addr[1:0]);
                        read_nxt    = ~sel_op[3];
                        write_nxt   = sel_op[3];
                        if (sel_op[3]) begin
                            writedata_nxt = store_data(sel_op, d_wdata);
                        end
                    end
                end
            end
            S_BUS: begin
                if (!waitrequest) begin
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    state_nxt   = S_RESP;
                    d_valid_nxt = is_data_q;
                    f_valid_nxt = ~is_data_q;
                    rdata_nxt   = op_q[3] ? 32'd0 : load_steer(op_q, alo_q, readdata, wdata_q);
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    state_nxt   = S_RESP;
                    d_valid_nxt = is_data_q;
                    f_valid_nxt = ~is_data_q;
                    err_nxt     = 1'b1;
                    rdata_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

    assign ready_nxt = (state_nxt == S_IDLE);

    // State and output registers; reset drops strobes without a response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            is_data_q  <= 1'b0;
            op_q       <= '0;
            alo_q      <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ready      <= 1'b1;
            mem_halt   <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            rdata      <= '0;
            f_valid    <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            is_data_q  <= is_data_nxt;
            op_q       <= op_nxt;
            alo_q      <= alo_nxt;
            wdata_q    <= wdata_nxt;
            cnt_q      <= cnt_nxt;
            ready      <= ready_nxt;
            mem_halt   <= ~ready_nxt;
            address    <= address_nxt;
            byteenable <= be_nxt;
            writedata  <= writedata_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            rdata      <= rdata_nxt;
            f_valid    <= f_valid_nxt;
            d_valid    <= d_valid_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written arbitration
// and reset sequences, and randomized transfers against a behavioural model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req, d_req, waitrequest;
    logic [31:0] f_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_op;
    logic        ready, f_valid, d_valid, err, mem_halt, read, write;
    logic [31:0] rdata, address, writedata;
    logic [3:0]  byteenable;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd;
        bit          err;
        bit          nobus;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          store;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mem;
        int          nwait;
        logic [31:0] rd;
        bit          err;
        bit          nobus;
        logic [3:0]  be;
        logic [31:0] bwd;
    } vec_t;

    mem_access_unit #(.TIMEOUT(TO), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .ready(ready), .f_valid(f_valid), .d_valid(d_valid), .rdata(rdata), .err(err),
        .mem_halt(mem_halt), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: MIPS lane rules computed with plain shifts and arithmetic
    function automatic exp_t model(input bit fetch, input int op_in, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] mem, input int nwait);
        exp_t e;
        int op, a, sh;
        bit legal, mis;
        longint unsigned m, r, v;
        op = fetch ? 4 : op_in;
        a  = int'(addr[1:0]);
        m  = 64'(mem);
        r  = 64'(wdata);
        legal = ((op >= 0) && (op <= 6)) || ((op >= 8) && (op <= 10));
        mis   = (((op == 2) || (op == 3) || (op == 9)) && (a % 2 != 0)) ||
                (((op == 4) || (op == 10)) && (a != 0));
        e.store = (op >= 8);
        if (op == 0 || op == 1 || op == 8)      e.be = 4'(1 << a);
        else if (op == 2 || op == 3 || op == 9) e.be = (a < 2) ? 4'h3 : 4'hC;
        else                                    e.be = 4'hF;
        case (op)
            8:       v = (r & 64'hFF) * 64'h01010101;
            9:       v = (r & 64'hFFFF) * 64'h00010001;
            default: v = r;
        endcase
        e.wd = 32'(v);
        case (op)
            0, 1: begin
                v = (m >> (8 * a)) & 64'hFF;
                if (op == 0 && v >= 64'h80) v += 64'hFFFFFF00;
            end
            2, 3: begin
                v = (m >> (16 * (a / 2))) & 64'hFFFF;
                if (op == 2 && v >= 64'h8000) v += 64'hFFFF0000;
            end
            4: v = m;
            5: begin
                sh = 8 * (3 - a);
                v  = (m << sh) | (r & ((64'd1 << sh) - 64'd1));
            end
            6: begin
                sh = 8 * a;
                v  = (m >> sh) | (r & ~(64'hFFFFFFFF >> sh));
            end
            default: v = 0;
        endcase
        e.nobus = !legal || mis;
        e.err   = e.nobus || (TO > 0 && nwait >= TO);
        e.rd    = e.err ? 32'd0 : 32'(v);
        return e;
    endfunction

    // One transfer: request, bus responder with nwait stall cycles, response checks
    task automatic run_txn(input bit fq, input bit dq, input logic [3:0] op,
                           input logic [31:0] fa, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] mem,
                           input int nwait, input bit e_data, input exp_t e);
        int k, cyc, lat, n_str, e_lat;
        bit got;
        logic [31:0] e_addr;
        k = 0;
        while (!ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_req", 32'(ready), 32'd1);
        f_req = fq; d_req = dq; f_addr = fa; d_addr = da; d_op = op; d_wdata = wd;
        waitrequest = 1'b0;
        readdata = $urandom;
        @(posedge clk); #1;
        if (e_data) d_req = 1'b0;
        else        f_req = 1'b0;
        chk("halt_after_accept", 32'({ready, mem_halt}), 32'b01);
        e_addr = e_data ? {da[31:2], 2'b00} : {fa[31:2], 2'b00};
        n_str  = e.nobus ? 0 : ((TO > 0 && nwait >= TO) ? TO : nwait + 1);
        e_lat  = e.nobus ? 1 : n_str + 1;
        cyc = 0; lat = 1; got = 1'b0;
        while (!got && lat < 40) begin
            if (f_valid || d_valid) begin
                got = 1'b1;
            end else begin
                if (read || write) begin
                    chk("strobe_kind", 32'({read, write}), e.store ? 32'b01 : 32'b10);
                    chk("address", address, e_addr);
                    chk("byteenable", 32'(byteenable), 32'(e.be));
                    if (e.store) chk("writedata", writedata, e.wd);
                    waitrequest = (cyc < nwait);
                    readdata    = waitrequest ? $urandom : mem;
                    cyc++;
                end else begin
                    waitrequest = 1'b0;
                    readdata    = $urandom;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("valid_seen", 32'(got), 32'd1);
        chk("strobe_cycles", 32'(cyc), 32'(n_str));
        chk("latency", 32'(lat), 32'(e_lat));
        chk("no_strobe_in_resp", 32'({read, write}), 32'd0);
        chk("valid_sel", 32'({f_valid, d_valid}), e_data ? 32'b01 : 32'b10);
        chk("err", 32'(err), 32'(e.err));
        chk("rdata", rdata, e.rd);
        waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("valid_pulse", 32'({f_valid, d_valid, err, ready}), 32'b0001);
    endtask

    vec_t vecs[19];
    int   legal_ops[10] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10};

    initial begin
        exp_t e;
        vec_t v;
        bit   fetch;
        int   op, nw;
        logic [31:0] addr, wd, mem;

        vecs[0]  = '{4'd4,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0};
        vecs[1]  = '{4'd0,  32'h103, 32'h0,        32'h80000000, 3, 32'hFFFFFF80, 0, 0, 4'h8, 32'h0};
        vecs[2]  = '{4'd1,  32'h103, 32'h0,        32'h80000000, 3, 32'h00000080, 0, 0, 4'h8, 32'h0};
        vecs[3]  = '{4'd9,  32'h102, 32'h1234ABCD, 32'h0,        0, 32'h0,        0, 0, 4'hC, 32'hABCDABCD};
        vecs[4]  = '{4'd5,  32'h101, 32'h11223344, 32'hAABBCCDD, 0, 32'hCCDD3344, 0, 0, 4'hF, 32'h0};
        vecs[5]  = '{4'd6,  32'h101, 32'h11223344, 32'hAABBCCDD, 0, 32'h11AABBCC, 0, 0, 4'hF, 32'h0};
        vecs[6]  = '{4'd2,  32'h101, 32'h0,        32'h12345678, 0, 32'h0,        1, 1, 4'h0, 32'h0};
        vecs[7]  = '{4'd7,  32'h100, 32'h0,        32'h12345678, 0, 32'h0,        1, 1, 4'h0, 32'h0};
        vecs[8]  = '{4'd10, 32'h102, 32'h55,       32'h0,        0, 32'h0,        1, 1, 4'h0, 32'h0};
        vecs[9]  = '{4'd8,  32'h001, 32'h000000A5, 32'h0,        1, 32'h0,        0, 0, 4'h2, 32'hA5A5A5A5};
        vecs[10] = '{4'd3,  32'h102, 32'h0,        32'h80011234, 2, 32'h00008001, 0, 0, 4'hC, 32'h0};
        vecs[11] = '{4'd2,  32'h102, 32'h0,        32'h80011234, 2, 32'hFFFF8001, 0, 0, 4'hC, 32'h0};
        vecs[12] = '{4'd4,  32'h300, 32'h0,        32'hCAFEF00D, 6, 32'h0,        1, 0, 4'hF, 32'h0};
        vecs[13] = '{4'd5,  32'h103, 32'h11223344, 32'hAABBCCDD, 0, 32'hAABBCCDD, 0, 0, 4'hF, 32'h0};
        vecs[14] = '{4'd6,  32'h100, 32'h11223344, 32'hAABBCCDD, 0, 32'hAABBCCDD, 0, 0, 4'hF, 32'h0};
        vecs[15] = '{4'd2,  32'h100, 32'h0,        32'h00007FFF, 1, 32'h00007FFF, 0, 0, 4'h3, 32'h0};
        vecs[16] = '{4'd10, 32'h104, 32'h89ABCDEF, 32'h0,        4, 32'h0,        1, 0, 4'hF, 32'h89ABCDEF};
        vecs[17] = '{4'd4,  32'h104, 32'h0,        32'h12345678, 3, 32'h12345678, 0, 0, 4'hF, 32'h0};
        vecs[18] = '{4'd0,  32'h102, 32'h0,        32'h00FE0000, 0, 32'hFFFFFFFE, 0, 0, 4'h4, 32'h0};

        reset_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_op = '0; readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({ready, mem_halt, read, write, f_valid, d_valid, err}), 32'b1000000);
        chk("reset_address", address, 32'd0);
        chk("reset_byteenable", 32'(byteenable), 32'd0);
        chk("reset_writedata", writedata, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the data port
        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            e.rd = v.rd; e.err = v.err; e.nobus = v.nobus;
            e.be = v.be; e.wd = v.bwd; e.store = v.op[3];
            run_txn(1'b0, 1'b1, v.op, 32'h0, v.addr, v.wd, v.mem, v.nwait, 1'b1, e);
        end

        // Simultaneous requests: data first, held fetch taken on the next IDLE
        e = model(1'b0, 4, 32'h500, 32'h0, 32'h0BADF00D, 0);
        run_txn(1'b1, 1'b1, 4'd4, 32'h400, 32'h500, 32'h0, 32'h0BADF00D, 0, 1'b1, e);
        chk("fetch_still_held", 32'(f_req), 32'd1);
        e = model(1'b1, 4, 32'h400, 32'h0, 32'h24080001, 1);
        run_txn(1'b1, 1'b0, 4'd4, 32'h400, 32'h500, 32'h0, 32'h24080001, 1, 1'b0, e);

        // Misaligned fetch reports err without a bus cycle
        e = model(1'b1, 4, 32'h402, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 4'd0, 32'h402, 32'h0, 32'h0, 32'h0, 0, 1'b0, e);

        // Randomized transfers against the model
        for (int i = 0; i < 200; i++) begin
            fetch = ($urandom % 5 == 0);
            op    = ($urandom % 8 == 0) ? int'($urandom % 16) : legal_ops[$urandom % 10];
            addr  = $urandom;
            if ($urandom % 2 == 0) addr = addr & ~32'h3;
            wd    = $urandom;
            mem   = $urandom;
            nw    = ($urandom % 8 == 0) ? 4 + int'($urandom % 2) : int'($urandom % 4);
            e     = model(fetch, op, addr, wd, mem, nw);
            if (fetch)
                run_txn(1'b1, 1'b0, 4'($urandom), addr, $urandom, wd, mem, nw, 1'b0, e);
            else
                run_txn(1'b0, 1'b1, 4'(op), $urandom, addr, wd, mem, nw, 1'b1, e);
        end

        // Reset in the middle of a stalled bus cycle
        d_req = 1'b1; d_op = 4'd4; d_addr = 32'h700; waitrequest = 1'b1;
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("midbus_read_high", 32'({read, write}), 32'b10);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midbus_reset_strobes", 32'({read, write}), 32'd0);
        chk("midbus_reset_ready", 32'({ready, mem_halt}), 32'b10);
        reset_n = 1'b1;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("midbus_no_response", 32'({f_valid, d_valid, err}), 32'd0);

        // Normal operation after the reset
        e = model(1'b0, 4, 32'h704, 32'h0, 32'h600DCAFE, 0);
        run_txn(1'b0, 1'b1, 4'd4, 32'h0, 32'h704, 32'h0, 32'h600DCAFE, 0, 1'b1, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
